bus_timer: RTL and testbench

- Memory-mapped 32-bit countdown timer.
- Acts as a responder on the microSystem device bus: the CPU/bridge is the initiator, and this block decodes register accesses and returns read data.
- Counts down from a programmable preset and raises an interrupt line to the CPU's interrupt controller.
- Supports one-shot and auto-reload modes.

---
 rtl/timer_pkg.sv | 39 +++
 rtl/timer_prescaler.sv | 37 +++
 rtl/bus_timer.sv | 139 +++++++++++++
 tb/tb_bus_timer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared register map, CTRL bit layout, mode codes and FSM
//                state encoding for the bus_timer block.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

   // Word offsets (addr[3:2]) of the bus-visible registers
   localparam logic [1:0] CTRL_ADDR   = 2'd0;
   localparam logic [1:0] PRESET_ADDR = 2'd1;
   localparam logic [1:0] COUNT_ADDR  = 2'd2;

   // CTRL register layout; bits above IM read as zero
   localparam int EN_BIT    = 0;
   localparam int MODE_LSB  = 1;
   localparam int MODE_MSB  = 2;
   localparam int IM_BIT    = 3;
   localparam int CTRL_BITS = 4;

   // Mode field codes; the two unlisted codes behave as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timer_state_t;

   // Only the exact reload code re-arms; everything else stops after firing
   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Count-step tick generator. While run is high it emits a
//                one-cycle tick every PRESCALE cycles; it restarts from zero
//                whenever run drops.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int             CW   = $clog2(PRESCALE);
   localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] div;

   assign tick = run & (div == LAST);

   // Divider counter: held at zero outside the counting phase, wraps on tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div <= '0;
      end else if (!run || tick) begin
         div <= '0;
      end else begin
         div <= div + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer
//  Description : Memory-mapped countdown timer responding on the device bus.
//                CTRL/PRESET are writable, COUNT is read-only; counts down
//                from PRESET and raises a level interrupt, in one-shot or
//                auto-reload mode.
//                Build option TIMER_PRESCALE_EN: when defined, COUNT steps
//                only once every PRESCALE cycles via timer_prescaler.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_timer #(
   parameter int WIDTH    = 32,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sel,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             irq
);

   import timer_pkg::*;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   timer_state_t           state;
   logic [CTRL_BITS-1:0]   ctrl;
   logic [WIDTH-1:0]       preset;
   logic [WIDTH-1:0]       count;
   logic                   irq_pending;

   logic                   wr_ctrl;
   logic                   wr_preset;
   logic [1:0]             mode;
   logic                   step;

   assign wr_ctrl   = sel & we & (addr == CTRL_ADDR);
   assign wr_preset = sel & we & (addr == PRESET_ADDR);
   assign mode      = ctrl[MODE_MSB:MODE_LSB];
   assign irq       = irq_pending & ctrl[IM_BIT];

   // Prescaler needs at least two cycles per step to be meaningful
   if (PRESCALE < 2) begin : g_prescale_range
      $error("bus_timer: PRESCALE must be at least 2");
   end

`ifdef TIMER_PRESCALE_EN
   // Count steps are gated by the divider, which only runs while counting
   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (state == CNT),
      .tick  (step)
   );
`else
   assign step = 1'b1;
`endif

   // Register file and countdown FSM; bus writes are applied last so they
   // override any same-edge FSM update of CTRL or irq_pending
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ctrl        <= '0;
         preset      <= '0;
         count       <= '0;
         irq_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl[EN_BIT]) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!ctrl[EN_BIT]) begin
                  state <= IDLE;
               end else if (step) begin
                  // PRESET of 0 and 1 both expire here, never wrapping
                  if (count <= ONE) begin
                     count       <= '0;
                     irq_pending <= 1'b1;
                     state       <= INT;
                  end else begin
                     count <= count - ONE;
                  end
               end
            end
            INT: begin
               if (is_reload(mode)) begin
                  irq_pending <= 1'b0;
                  state       <= LOAD;
               end else begin
                  ctrl[EN_BIT] <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (wr_ctrl) begin
            ctrl <= wdata[CTRL_BITS-1:0];
         end
         if (wr_preset) begin
            preset <= wdata;
         end
         if (wr_ctrl || wr_preset) begin
            irq_pending <= 1'b0;
         end
      end
   end

   // Read mux: zero when not selected or for the reserved slot
   always_comb begin
      rdata = '0;
      if (sel) begin
         case (addr)
            CTRL_ADDR:   rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl};
            PRESET_ADDR: rdata = preset;
            COUNT_ADDR:  rdata = count;
            default:     rdata = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_timer
//  Description : Self-checking bench for bus_timer (default build). Random
//                one-shot / auto-reload runs are compared against a
//                closed-form timeline model; directed cases cover register
//                access corner cases, masking, disable and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_timer;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        sel   = 1'b0;
   logic        we    = 1'b0;
   logic [1:0]  addr  = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bus_timer #(
      .WIDTH    (32),
      .PRESCALE (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance one clock edge and settle just after it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Bus write; the write lands on the next rising edge
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      sel   = 1'b0;
      we    = 1'b0;
      wdata = 32'd0;
   endtask

   // Combinational read between edges
   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      sel  = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      d    = rdata;
      sel  = 1'b0;
   endtask

   task automatic hard_reset();
      sel   = 1'b0;
      we    = 1'b0;
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
   endtask

   // ---------------- timeline model ----------------
   // t = number of edges since the arming CTRL write (t=0 is that edge),
   // starting from reset values. m = max(N,1) count steps; reload period m+2.
   function automatic int steps(input int n);
      return (n < 1) ? 1 : n;
   endfunction

   function automatic int phase(input int n, input bit reload, input int t);
      if (reload) return (t - 1) % (steps(n) + 2);
      return t - 1;
   endfunction

   function automatic logic [31:0] m_count(input int n, input bit reload, input int t);
      int r;
      if (t <= 1) return 32'd0;
      r = phase(n, reload, t);
      if (r >= 1 && r <= steps(n)) return 32'(n - (r - 1));
      return 32'd0;
   endfunction

   function automatic logic m_irq(input int n, input bit reload, input logic im, input int t);
      int r;
      if (t <= 1) return 1'b0;
      r = phase(n, reload, t);
      if (reload) return im & (r == steps(n) + 1);
      return im & (r >= steps(n) + 1);
   endfunction

   function automatic logic [31:0] m_ctrl(input int n, input bit reload, input logic im,
                                          input logic [1:0] mode, input int t);
      logic en;
      en = reload ? 1'b1 : (t < steps(n) + 3);
      return {28'd0, im, mode, en};
   endfunction

   // ---------------- stimulus ----------------
   logic [31:0] d;
   int          n_v;
   int          horizon;
   logic [1:0]  mode_v;
   logic        im_v;
   bit          reload_v;
   logic [31:0] exp_pr [6];

   initial begin
      // Reset held low with random bus traffic: nothing may stick
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sel   = 1'b1;
         we    = 1'b1;
         addr  = 2'($urandom_range(0, 3));
         wdata = $urandom;
         cyc();
         for (int a = 0; a < 3; a++) begin
            peek(2'(a), d);
            check($sformatf("rst_read a%0d c%0d", a, i), d, 32'd0);
         end
         check($sformatf("rst_irq c%0d", i), {31'd0, irq}, 32'd0);
      end
      we    = 1'b0;
      reset = 1'b1;
      cyc();

      // Randomized one-shot / auto-reload runs against the timeline model
      for (int trial = 0; trial < 16; trial++) begin
         n_v      = int'($urandom_range(0, 6));
         mode_v   = 2'($urandom_range(0, 3));
         im_v     = 1'($urandom_range(0, 1));
         reload_v = (mode_v == 2'b01);
         horizon  = 3 * (steps(n_v) + 2) + 1;
         hard_reset();
         bus_wr(2'd1, 32'(n_v));
         bus_wr(2'd0, {28'd0, im_v, mode_v, 1'b1});
         for (int t = 1; t <= horizon; t++) begin
            cyc();
            peek(2'd2, d);
            check($sformatf("count tr%0d t%0d", trial, t), d, m_count(n_v, reload_v, t));
            check($sformatf("irq tr%0d t%0d", trial, t), {31'd0, irq},
                  {31'd0, m_irq(n_v, reload_v, im_v, t)});
            peek(2'd0, d);
            check($sformatf("ctrl tr%0d t%0d", trial, t), d,
                  m_ctrl(n_v, reload_v, im_v, mode_v, t));
         end
         if (!reload_v) begin
            bus_wr(2'd0, {28'd0, im_v, mode_v, 1'b0});
            check($sformatf("irq_clr tr%0d", trial), {31'd0, irq}, 32'd0);
         end
      end

      // Read-only and reserved addresses, upper CTRL bits, unselected read
      hard_reset();
      bus_wr(2'd1, 32'd5);
      bus_wr(2'd0, 32'hFFFF_FFF8);
      bus_wr(2'd2, 32'hFFFF_FFFF);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      peek(2'd0, d); check("ro_ctrl", d, 32'h8);
      peek(2'd1, d); check("ro_preset", d, 32'd5);
      peek(2'd2, d); check("ro_count", d, 32'd0);
      peek(2'd3, d); check("ro_reserved", d, 32'd0);
      addr = 2'd1;
      sel  = 1'b0;
      #1;
      check("unselected_read", rdata, 32'd0);

      // Masked interrupt: fires internally, never reaches irq
      hard_reset();
      bus_wr(2'd1, 32'd1);
      bus_wr(2'd0, 32'h1);
      for (int t = 1; t <= 5; t++) begin
         cyc();
         check($sformatf("mask_irq t%0d", t), {31'd0, irq}, 32'd0);
         peek(2'd0, d);
         check($sformatf("mask_ctrl t%0d", t), d, m_ctrl(1, 1'b0, 1'b0, 2'b00, t));
      end
      bus_wr(2'd0, 32'h8);
      check("unmask_irq", {31'd0, irq}, 32'd0);
      cyc();
      check("unmask_irq2", {31'd0, irq}, 32'd0);

      // Disable mid-count: COUNT freezes at 5, re-enable reloads from PRESET
      hard_reset();
      bus_wr(2'd1, 32'd8);
      bus_wr(2'd0, 32'h9);
      for (int t = 1; t <= 4; t++) cyc();
      bus_wr(2'd0, 32'h8);
      for (int t = 0; t < 4; t++) begin
         peek(2'd2, d);
         check($sformatf("hold_count c%0d", t), d, 32'd5);
         check($sformatf("hold_irq c%0d", t), {31'd0, irq}, 32'd0);
         cyc();
      end
      bus_wr(2'd0, 32'h9);
      cyc();
      cyc();
      peek(2'd2, d); check("reenable_count", d, 32'd8);
      cyc();
      cyc();
      // Asynchronous reset mid-count clears everything without a clock edge
      reset = 1'b0;
      #1;
      for (int a = 0; a < 3; a++) begin
         peek(2'(a), d);
         check($sformatf("midrst a%0d", a), d, 32'd0);
      end
      check("midrst_irq", {31'd0, irq}, 32'd0);
      cyc();
      reset = 1'b1;
      cyc();

      // Bus CTRL write on the INT edge beats the hardware EN clear
      hard_reset();
      bus_wr(2'd1, 32'd1);
      bus_wr(2'd0, 32'h9);
      cyc(); cyc(); cyc();
      check("win_irq_pre", {31'd0, irq}, 32'd1);
      bus_wr(2'd0, 32'hB);
      peek(2'd0, d); check("win_ctrl", d, 32'hB);
      check("win_irq", {31'd0, irq}, 32'd0);
      cyc();
      cyc();
      peek(2'd2, d); check("win_reload_count", d, 32'd1);
      cyc();
      check("win_refire", {31'd0, irq}, 32'd1);

      // PRESET rewrite during CNT only affects the next reload
      hard_reset();
      bus_wr(2'd1, 32'd3);
      bus_wr(2'd0, 32'hB);
      cyc();
      cyc();
      exp_pr = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd7, 32'd6};
      bus_wr(2'd1, 32'd7);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) cyc();
         peek(2'd2, d);
         check($sformatf("prw_count i%0d", i), d, exp_pr[i]);
         check($sformatf("prw_irq i%0d", i), {31'd0, irq}, (i == 2) ? 32'd1 : 32'd0);
      end
      peek(2'd1, d); check("prw_preset", d, 32'd7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
